// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit that sits beside the ALU in EX.
// One operation per accepted start; busy_o stalls the pipeline until the tagged result returns.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       asynchronous active-low reset
//   start_i     launch request, sampled only while idle
//   op_i        RV32M funct3 (0 MUL .. 7 REMU)
//   rs1_data_i  operand A (dividend / multiplicand)
//   rs2_data_i  operand B (divisor / multiplier)
//   rd_i        destination tag captured with the operands
//   flush_i     abort the in-flight operation; beats start_i in idle
//   busy_o      high whenever the unit is not idle
//   done_o      one-cycle result-valid pulse
//   result_o    result, held until a later operation completes
//   rd_o        tag belonging to result_o
//
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
// Division stays iterative either way.
module muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RD_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [RD_W-1:0] rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [RD_W-1:0] rd_o
);

  localparam int unsigned     CntW    = $clog2(XLEN) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinVal  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e              r_state, w_state_nxt;
  logic [CntW-1:0]     r_cnt, w_cnt_nxt;
  logic [2:0]          r_op, w_op_nxt;
  logic [RD_W-1:0]     r_rd, w_rd_nxt;
  logic                r_neg, w_neg_nxt;
  logic [XLEN-1:0]     r_a, w_a_nxt;
  logic [XLEN-1:0]     r_b, w_b_nxt;
  logic [2*XLEN-1:0]   r_prod, w_prod_nxt;
  logic [XLEN-1:0]     r_quot, w_quot_nxt;
  logic [XLEN-1:0]     r_rem, w_rem_nxt;
  logic [XLEN-1:0]     r_result, w_result_nxt;
  logic [RD_W-1:0]     r_rd_out, w_rd_out_nxt;

  // Pick the low or high half of the product after applying the sign.
  function automatic logic [XLEN-1:0] mul_sel(input logic [2*XLEN-1:0] prod, input logic lo,
                                              input logic neg);
    logic [2*XLEN-1:0] p;
    p = neg ? -prod : prod;
    return lo ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_sel(input logic [XLEN-1:0] quot,
                                              input logic [XLEN-1:0] rem, input logic is_rem,
                                              input logic neg);
    logic [XLEN-1:0] v;
    v = is_rem ? rem : quot;
    return neg ? -v : v;
  endfunction

  // Operand decode: rs1 is signed for MUL/MULH/MULHSU/DIV/REM, rs2 for MUL/MULH/DIV/REM.
  logic            w_a_signed, w_b_signed, w_sa, w_sb, w_neg;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_bypass;
  logic            w_div_zero, w_div_ovf;

  always_comb begin
    w_a_signed = op_i[2] ? ~op_i[0] : (op_i != 3'd3);
    w_b_signed = op_i[2] ? ~op_i[0] : ~op_i[1];
    w_sa       = w_a_signed & rs1_data_i[XLEN-1];
    w_sb       = w_b_signed & rs2_data_i[XLEN-1];
    w_mag_a    = w_sa ? -rs1_data_i : rs1_data_i;
    w_mag_b    = w_sb ? -rs2_data_i : rs2_data_i;
    // Remainder follows the dividend; product and quotient follow the XOR of signs.
    w_neg      = (op_i[2] & op_i[1]) ? w_sa : (w_sa ^ w_sb);
    w_div_zero = (rs2_data_i == '0);
    w_div_ovf  = ~op_i[0] & (rs1_data_i == MinVal) & (rs2_data_i == '1);
    if (w_div_zero) w_bypass = op_i[1] ? rs1_data_i : '1;
    else            w_bypass = op_i[1] ? '0 : rs1_data_i;
  end

  // Shift-add multiply step: conditionally add multiplicand to the upper half, shift right.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_prod_step;
  // Restoring divide step: trial-subtract divisor from the shifted partial remainder.
  logic [XLEN:0]     w_trial;
  logic [XLEN-1:0]   w_rem_step, w_quot_step;

  always_comb begin
    w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_a} : '0);
    w_prod_step = {w_mul_sum, r_prod[XLEN-1:1]};
    w_trial     = {r_rem, r_quot[XLEN-1]} - {1'b0, r_b};
    w_rem_step  = w_trial[XLEN] ? {r_rem[XLEN-2:0], r_quot[XLEN-1]} : w_trial[XLEN-1:0];
    w_quot_step = {r_quot[XLEN-2:0], ~w_trial[XLEN]};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_op_nxt     = r_op;
    w_rd_nxt     = r_rd;
    w_neg_nxt    = r_neg;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_prod_nxt   = r_prod;
    w_quot_nxt   = r_quot;
    w_rem_nxt    = r_rem;
    w_result_nxt = r_result;
    w_rd_out_nxt = r_rd_out;
    case (r_state)
      StIdle: begin
        if (start_i && !flush_i) begin
          w_op_nxt  = op_i;
          w_rd_nxt  = rd_i;
          w_neg_nxt = w_neg;
          w_cnt_nxt = '0;
          w_a_nxt   = w_mag_a;
          w_b_nxt   = w_mag_b;
          if (!op_i[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            w_result_nxt = mul_sel(w_fast_prod, op_i == 3'd0, w_neg);
            w_rd_out_nxt = rd_i;
            w_state_nxt  = StDone;
`else
            w_prod_nxt  = {{XLEN{1'b0}}, w_mag_b};
            w_state_nxt = StMul;
`endif
          end else if (w_div_zero || w_div_ovf) begin
            w_result_nxt = w_bypass;
            w_rd_out_nxt = rd_i;
            w_state_nxt  = StDone;
          end else begin
            w_quot_nxt  = w_mag_a;
            w_rem_nxt   = '0;
            w_state_nxt = StDiv;
          end
        end
      end
      StMul: begin
        if (flush_i) begin
          w_state_nxt = StIdle;
        end else begin
          w_prod_nxt = w_prod_step;
          w_cnt_nxt  = r_cnt + 1'b1;
          if (r_cnt == CntLast) begin
            w_result_nxt = mul_sel(w_prod_step, r_op == 3'd0, r_neg);
            w_rd_out_nxt = r_rd;
            w_state_nxt  = StDone;
          end
        end
      end
      StDiv: begin
        if (flush_i) begin
          w_state_nxt = StIdle;
        end else begin
          w_quot_nxt = w_quot_step;
          w_rem_nxt  = w_rem_step;
          w_cnt_nxt  = r_cnt + 1'b1;
          if (r_cnt == CntLast) begin
            w_result_nxt = div_sel(w_quot_step, w_rem_step, r_op[1], r_neg);
            w_rd_out_nxt = r_rd;
            w_state_nxt  = StDone;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_neg    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_prod   <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op     <= w_op_nxt;
      r_rd     <= w_rd_nxt;
      r_neg    <= w_neg_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_prod   <= w_prod_nxt;
      r_quot   <= w_quot_nxt;
      r_rem    <= w_rem_nxt;
      r_result <= w_result_nxt;
      r_rd_out <= w_rd_out_nxt;
    end
  end

  assign busy_o   = (r_state != StIdle);
  assign done_o   = (r_state == StDone) && !flush_i;
  assign result_o = r_result;
  assign rd_o     = r_rd_out;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide execution unit for the RV32M extension in the 5-stage pipeline; sits beside the ALU in EX.
- Accepts one operation per start, asserts busy so hazard logic holds PC/IFID/IDEX, then returns a tagged result with rd for EXMEM/writeback.
- Width is parametrised, so the same unit serves 32- and 64-bit cores.

Parameters:
- XLEN, 32, operand/result width; must be an even value ≥ 8.
- RD_W, 5, width of the destination-register tag.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- start_i  input  1  launch request; sampled only in IDLE.
- op_i  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_data_i  input  XLEN  operand A (dividend / multiplicand).
- rs2_data_i  input  XLEN  operand B (divisor / multiplier).
- rd_i  input  RD_W  destination tag, captured with the operands.
- flush_i  input  1  abort the in-flight operation (branch flush).
- busy_o  output  1  high whenever state != IDLE.
- done_o  output  1  one-cycle result-valid pulse.
- result_o  output  XLEN  result; holds its value until the next accepted start.
- rd_o  output  RD_W  captured tag; holds its value like result_o.

Behaviour:
- Reset: rst_i low forces state IDLE immediately, regardless of clock. busy_o, done_o, result_o, rd_o and all internal registers go to 0. This applies mid-operation too; no result is produced.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start_i=1, flush_i=0:
  - Capture operands, op and rd; clear counter cnt to 0.
  - Go to MUL (op<4) or DIV (op≥4).
  - Signed ops convert operands to magnitudes and record the result sign.
- IDLE with flush_i=1: start_i is ignored.
- MUL:
  - One shift-add step per cycle on a 2·XLEN product register.
  - After XLEN steps (cnt = XLEN-1), go to DONE.
- DIV:
  - One restoring step per cycle; quotient and remainder are each XLEN bits.
  - After XLEN steps, go to DONE.
- Latency: start edge at cycle 0 → done_o=1 during cycle XLEN+1 (33 for XLEN=32). busy_o is high in cycles 1..XLEN+1.
- DONE:
  - done_o=1 and result_o/rd_o are valid.
  - Next cycle go to IDLE; done_o returns to 0 and result_o/rd_o stay stable.
- Result selection:
  - MUL → low XLEN bits of the product.
  - MULH, MULHSU, MULHU → high XLEN bits.
  - DIV/DIVU → quotient; REM/REMU → remainder.
- Sign fixup, applied on entry to DONE:
  - Negate the product if the operand signs differ (MULH; for MULHSU, rs1 only).
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
- Divide by zero (rs2=0): bypass iteration and go IDLE → DONE directly (latency 1).
  - Quotient = all ones.
  - Remainder = rs1.
- Signed overflow (DIV/REM, rs1 = most negative value, rs2 = -1): bypass, latency 1.
  - Quotient = rs1.
  - Remainder = 0.
- flush_i=1 in MUL, DIV or DONE:
  - Next state is IDLE and done_o is forced to 0 in that cycle.
  - result_o/rd_o keep their previous values.
- start_i while busy_o=1 is ignored; no queueing.
- Simultaneous start_i and flush_i in IDLE: flush wins and nothing launches.
- All arithmetic is modulo 2·XLEN internally. cnt is $clog2(XLEN)+1 bits and never wraps during an operation.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU compute a combinational 2·XLEN product in one cycle: IDLE → DONE, done_o in cycle 1.
  - Division is unchanged.
- Undefined: the iterative multiplier with XLEN+1 latency; no multiplier array is inferred.

Test Plan:
- Reset with rst_i=0 → all outputs 0 and busy_o=0. Pulse rst_i low in cycle 10 of a DIV → busy_o=0 at once, done_o never rises.
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD), rd=5 → done_o in cycle 33, result_o=0xFFFFFFEB, rd_o=5. MULH with the same operands → 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV -20 / 6 → quotient 0xFFFFFFFD (-3). REM → 0xFFFFFFFE (-2). DIVU 100 / 7 → 14. REMU → 2. Each reports done in cycle 33.
- DIVU 5 / 0 → result 0xFFFFFFFF, done in cycle 1. REM 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, done in cycle 1. REM with the same operands → 0.
- flush_i=1 in cycle 12 of a MUL → IDLE next cycle, no done_o, result_o unchanged. start_i+flush_i together in IDLE → busy_o stays 0. start_i at cycle 5 while busy → ignored; the first op's result is returned.
- With MULDIV_FAST_MUL_EN defined: MUL 0x10000 × 0x10000 → done_o in cycle 1, result_o=0. MULHU → 1.
